instruction_incrementer: RTL and testbench
==========================================

# instruction_incrementer

Program-counter incrementer for the MIPS fetch stage. Each enabled clock edge it registers `instruction + STEP` (next sequential fetch address) so the fetch loop can feed `out` back to `instruction`. It sits between the PC register/next-PC mux and instruction memory addressing, and flags address wrap-around.

## Interface
- `WIDTH`, 32: address width in bits.
- `STEP`, 4: byte increment per instruction. Must be a power of two and less than 2^WIDTH.
- `RESET_VALUE`, 0: value of `out` while in reset. Must be a multiple of `STEP`.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset. 0 forces reset immediately; release is sampled on `clk`.
- `en` input, 1 bit: active-high update enable. 0 holds all registered outputs.
- `instruction` input, WIDTH bits: current instruction address.
- `out` output, WIDTH bits: registered `instruction + STEP`.
- `wrap` output, 1 bit: registered carry-out of the last enabled increment.
- `misaligned` output, 1 bit: only present with `INSTR_ALIGN_CHECK_EN`. See Configuration.

## Operation
- Addition is unsigned, modulo 2^WIDTH. The carry-out goes to `wrap`.
- `en`=1 at a rising edge: `out` <= `instruction + STEP`, and `wrap` <= carry.
- `en`=0: `out` and `wrap` hold their values. `instruction` is ignored.
- `en` and `instruction` are sampled only at the edge. Glitches between edges have no effect.
- Boundary case: `instruction` = 2^WIDTH − STEP (32'hFFFF_FFFC) produces `out` = 0 and `wrap` = 1.
- `wrap` returns to 0 on the next enabled increment that does not carry.
- An X on `instruction` while `en`=0 must not propagate to the outputs.

## Timing
- Latency: one cycle from the `instruction` sampled at an enabled edge to `out`.
- Feedback loop: with `out` tied to `instruction` and `en`=1, `out` advances by `STEP` every cycle. Sequence after reset release: RESET_VALUE+4, +8, +12, …
- Reset assertion: asynchronous and immediate, regardless of `clk`. Drives `out`=RESET_VALUE, `wrap`=0, and `misaligned`=0.
- Reset release: the first update occurs on the first rising edge with `reset`=1 and `en`=1.
- Reset mid-operation: any in-flight value is discarded. There is no pending state.
- Reset and an enabled edge at the same time: reset wins.

## Configuration
- Macro: `INSTR_ALIGN_CHECK_EN`.
- Defined:
  - The `misaligned` port exists.
  - At each enabled edge, `misaligned` <= 1 if `instruction[log2(STEP)-1:0]` is nonzero.
  - The increment uses `instruction` with those low bits forced to 0, so `out` is always aligned. Example: instruction 32'h0000_0006 gives out 32'h0000_0008 and misaligned 1.
  - `misaligned` holds when `en`=0 and resets to 0.
- Undefined:
  - No `misaligned` port.
  - Low bits pass through the adder unmodified. Example: 32'h0000_0006 gives 32'h0000_000A.

## Structure
- Shared package `instr_incr_pkg` holds:
  - `addr_t` typedef: WIDTH-bit address.
  - `INSTR_STEP` constant: 4.
  - `PC_RESET_VALUE` constant: 0.
  - `ALIGN_BITS` constant: log2 of STEP.
- One sub-module, `incr_adder`: combinational WIDTH-bit add of a constant STEP with carry-out. The top level holds only the registers, the enable mux, reset, and the optional alignment logic.
- The clock generator is testbench-only and is not part of this block.

## Test plan
- Reset: hold `reset`=0 for 5 ns, including across a clock edge, with `instruction`=0x10 and `en`=1 → `out`=0, `wrap`=0 throughout.
- Feedback counting: release reset, `en`=1, drive `instruction`=`out` each cycle → `out` = 4, 8, 12, 16, 20, 24 on successive edges.
- Enable hold: `out`=0x20, then `en`=0 for 3 edges with `instruction`=0x100 → `out` stays 0x20. Re-enable → next edge gives 0x104.
- Wrap-around: `instruction`=32'hFFFF_FFFC, `en`=1 → `out`=0, `wrap`=1. Next with `instruction`=0 → `out`=4, `wrap`=0.
- Asynchronous reset mid-count: assert `reset`=0 between edges while `out`=0x40 → `out`=0 immediately, without waiting for an edge.
- Alignment (with macro): `instruction`=32'h0000_0006 → `out`=8, `misaligned`=1. Then `instruction`=8 → `out`=12, `misaligned`=0. Without the macro, 6 → 0xA.

Source files
------------

// File: rtl/instr_incr_pkg.sv
// instr_incr_pkg: shared address type and PC-incrementer constants
package instr_incr_pkg;
  localparam int ADDR_WIDTH     = 32;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  localparam int INSTR_STEP     = 4;
  localparam int PC_RESET_VALUE = 0;
  localparam int ALIGN_BITS     = $clog2(INSTR_STEP);
endpackage

// File: rtl/incr_adder.sv
// incr_adder: combinational WIDTH-bit add of constant STEP with carry-out
// Ports: a_i (operand), sum_o (a_i + STEP mod 2^WIDTH), carry_o (carry-out)
module incr_adder #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);
  assign {carry_o, sum_o} = {1'b0, a_i} + (WIDTH+1)'(STEP);
endmodule

// File: rtl/instruction_incrementer.sv
// instruction_incrementer: registered PC + STEP with wrap flag for the fetch stage
// Ports: clk, reset (async active-low), en (update enable), instruction (current PC),
//        out (registered instruction + STEP), wrap (registered carry-out),
//        misaligned (only when INSTR_ALIGN_CHECK_EN is defined)
// Build option: INSTR_ALIGN_CHECK_EN forces the low address bits to zero before
// the add and flags nonzero low bits on misaligned.
module instruction_incrementer
  import instr_incr_pkg::*;
#(
  parameter int WIDTH       = ADDR_WIDTH,
  parameter int STEP        = INSTR_STEP,
  parameter int RESET_VALUE = PC_RESET_VALUE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] instruction,
`ifdef INSTR_ALIGN_CHECK_EN
  output logic             misaligned,
`endif
  output logic [WIDTH-1:0] out,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(STEP - 1);
  logic [WIDTH-1:0] addr_in, sum, out_d, out_q;
  logic             carry, wrap_d, wrap_q;
`ifdef INSTR_ALIGN_CHECK_EN
  logic             mis_d, mis_q;
  assign addr_in = instruction & ~LOW_MASK;
  assign mis_d   = en ? |(instruction & LOW_MASK) : mis_q;
  assign misaligned = mis_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) mis_q <= 1'b0;
    else        mis_q <= mis_d;
`else
  assign addr_in = instruction;
`endif
  incr_adder #(.WIDTH(WIDTH), .STEP(STEP)) u_adder (
    .a_i     (addr_in),
    .sum_o   (sum),
    .carry_o (carry)
  );
  // en=0 selects the held value, so an unknown instruction never reaches the registers
  always_comb begin
    out_d  = en ? sum : out_q;
    wrap_d = en ? carry : wrap_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_q  <= WIDTH'(RESET_VALUE);
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  assign out  = out_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_instruction_incrementer.sv
// tb_instruction_incrementer: directed self-checking bench for instruction_incrementer
module tb_instruction_incrementer;
  logic        clk = 1'b0;
  logic        reset, en;
  logic [31:0] instruction, out, exp_out;
  logic        wrap;
`ifdef INSTR_ALIGN_CHECK_EN
  logic        misaligned;
`endif
  int errors = 0;
  int checks = 0;

  instruction_incrementer dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .instruction (instruction),
`ifdef INSTR_ALIGN_CHECK_EN
    .misaligned  (misaligned),
`endif
    .out         (out),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; instruction = 32'h10;
    #2;
    chk("reset_out", out, 32'h0);
    chk("reset_wrap", {31'b0, wrap}, 32'h0);
`ifdef INSTR_ALIGN_CHECK_EN
    chk("reset_mis", {31'b0, misaligned}, 32'h0);
`endif
    edge_step();
    chk("reset_edge_out", out, 32'h0);
    chk("reset_edge_wrap", {31'b0, wrap}, 32'h0);
    reset = 1'b1;
    exp_out = 32'h0;
    for (int i = 0; i < 8; i++) begin
      instruction = exp_out;
      edge_step();
      exp_out = exp_out + 32'd4;
      chk($sformatf("count_%0d", i), out, exp_out);
    end
    chk("count_final", out, 32'h20);
    en = 1'b0; instruction = 32'h100;
    for (int i = 0; i < 3; i++) begin
      edge_step();
      chk($sformatf("hold_%0d", i), out, 32'h20);
    end
    instruction = 32'hx;
    edge_step();
    chk("hold_x_out", out, 32'h20);
    chk("hold_x_wrap", {31'b0, wrap}, 32'h0);
    en = 1'b1; instruction = 32'h100;
    edge_step();
    chk("reenable", out, 32'h104);
    instruction = 32'hFFFF_FFFC;
    edge_step();
    chk("wrap_out", out, 32'h0);
    chk("wrap_flag", {31'b0, wrap}, 32'h1);
    en = 1'b0; instruction = 32'h0;
    edge_step();
    chk("wrap_hold", {31'b0, wrap}, 32'h1);
    en = 1'b1;
    edge_step();
    chk("wrap_clr_out", out, 32'h4);
    chk("wrap_clr_flag", {31'b0, wrap}, 32'h0);
    instruction = 32'h3C;
    edge_step();
    chk("pre_async", out, 32'h40);
    #2 reset = 1'b0;
    #1;
    chk("async_out", out, 32'h0);
    chk("async_wrap", {31'b0, wrap}, 32'h0);
    instruction = 32'h40;
    edge_step();
    chk("reset_wins", out, 32'h0);
    reset = 1'b1;
    edge_step();
    chk("post_reset", out, 32'h44);
    instruction = 32'h6;
    edge_step();
`ifdef INSTR_ALIGN_CHECK_EN
    chk("align6_out", out, 32'h8);
    chk("align6_mis", {31'b0, misaligned}, 32'h1);
    en = 1'b0;
    edge_step();
    chk("mis_hold", {31'b0, misaligned}, 32'h1);
    en = 1'b1; instruction = 32'h8;
    edge_step();
    chk("align8_out", out, 32'hC);
    chk("align8_mis", {31'b0, misaligned}, 32'h0);
`else
    chk("noalign6_out", out, 32'hA);
    instruction = 32'h7;
    edge_step();
    chk("noalign7_out", out, 32'hB);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
